// File: rtl/cordic_quadrant_ctrl.sv
// cordic_quadrant_ctrl: single-request sequencer around the CORDIC sin/cos core.
// Captures a reduced angle with its region flag and operation, starts the core,
// waits for done under a watchdog, selects cos or sin, applies the quadrant sign fix
// to the IEEE-754 sign bit and presents the result on a valid/ready port.
`timescale 1ns/1ps

module cordic_quadrant_ctrl #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_angle,
  input  logic         req_op,
  input  logic [1:0]   req_region,
  output logic         cordic_start,
  output logic [W-1:0] cordic_angle,
  input  logic         cordic_done,
  input  logic [W-1:0] cordic_cos,
  input  logic [W-1:0] cordic_sin,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         timeout_err,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_FIX   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wd;
  logic [CNT_W-1:0] wd_inc;
  logic             expire;
  logic             op_q;
  logic [1:0]       region_q;
  logic             flip;

  logic             req_ready_nxt;
  logic             cordic_start_nxt;
  logic             res_valid_nxt;
  logic             busy_nxt;

  // Watchdog expires once the WAIT phase has lasted TIMEOUT-1 cycles
  assign wd_inc = wd + CNT_W'(1);
  assign expire = (wd_inc == CNT_W'(TIMEOUT - 1));

  // Sign of cos flips in region 01, sign of sin flips in region 10
  assign flip = (!op_q && (region_q == 2'b01)) || (op_q && (region_q == 2'b10));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; done wins over watchdog expiry, abort skips FIX
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (cordic_done)  state_nxt = S_FIX;
        else if (expire)  state_nxt = S_OUT;
      end
      S_FIX:   state_nxt = S_OUT;
      S_OUT:   if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered below
  always_comb begin
    req_ready_nxt    = 1'b0;
    cordic_start_nxt = 1'b0;
    res_valid_nxt    = 1'b0;
    busy_nxt         = 1'b1;
    case (state_nxt)
      S_IDLE: begin
        req_ready_nxt = 1'b1;
        busy_nxt      = 1'b0;
      end
      S_START: cordic_start_nxt = 1'b1;
      S_OUT:   res_valid_nxt    = 1'b1;
      default: ;
    endcase
  end

  // Registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready    <= 1'b1;
      cordic_start <= 1'b0;
      res_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      req_ready    <= req_ready_nxt;
      cordic_start <= cordic_start_nxt;
      res_valid    <= res_valid_nxt;
      busy         <= busy_nxt;
    end
  end

  // Request capture, watchdog, result select and sign correction
  always_ff @(posedge clk) begin
    if (rst) begin
      cordic_angle <= '0;
      op_q         <= 1'b0;
      region_q     <= 2'b00;
      wd           <= '0;
      res_data     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cordic_angle <= req_angle;
            op_q         <= req_op;
            region_q     <= req_region;
            timeout_err  <= 1'b0;
          end
        end
        S_START: wd <= '0;
        S_WAIT: begin
          wd <= wd_inc;
          if (cordic_done) begin
            res_data <= op_q ? cordic_sin : cordic_cos;
          end else if (expire) begin
            res_data    <= '0;
            timeout_err <= 1'b1;
          end
        end
        S_FIX:   res_data <= {res_data[W-1] ^ flip, res_data[W-2:0]};
        default: ;
      endcase
    end
  end

endmodule
